// File: rtl/xalu_seq_if.sv
// Operand/result bundle for the digit-serial ALU: the requester (master)
// drives the operation request, the ALU (slave) returns status and results.
interface xalu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       func;
  logic             com;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci_right;
  logic             ci_left;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co_left;
  logic             co_right;
  logic             ovf;
  logic             zero;
  logic             neg_zero;
  logic             equ;

  modport master (
    output start, func, com, a, b, ci_right, ci_left,
    input  busy, done, result, co_left, co_right, ovf, zero, neg_zero, equ
  );

  modport slave (
    input  start, func, com, a, b, ci_right, ci_left,
    output busy, done, result, co_left, co_right, ovf, zero, neg_zero, equ
  );
endinterface

// File: rtl/xalu_seq.sv
// Digit-serial wide ALU. Operands are latched on start, then processed
// DIGIT bits per clock (LSB digit first) through one narrow slice with a
// carry register between digits. Result and flags are registered on the
// last digit edge together with a one-cycle done pulse.
module xalu_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic        clk,
  input logic        rst,
  xalu_seq_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] F_ADD   = 3'd0;
  localparam logic [2:0] F_AND   = 3'd1;
  localparam logic [2:0] F_OR    = 3'd2;
  localparam logic [2:0] F_XOR   = 3'd3;
  localparam logic [2:0] F_PASSA = 3'd4;
  localparam logic [2:0] F_PASSB = 3'd5;
  localparam logic [2:0] F_SHR   = 3'd6;
  localparam logic [2:0] F_SHL   = 3'd7;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_r, state_s;
  logic   load_s, step_s, finish_s, last_s;

  // Latched operation
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       func_r;
  logic             com_r, cir_r, cil_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] work_r;

  // Registered outputs
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             co_left_r, co_right_r, ovf_r, zero_r, neg_zero_r, equ_r;

  // Per-digit slice signals
  logic [WIDTH-1:0] shl_w_s, shr_w_s;
  logic [WIDTH-1:0] a_sh_s, b_sh_s, l_sh_s, r_sh_s;
  logic [DIGIT-1:0] a_dig_s, b_dig_s, shl_dig_s, shr_dig_s;
  logic [DIGIT:0]   sum_s;
  logic [DIGIT-1:0] raw_dig_s, out_dig_s;
  logic [WIDTH-1:0] word_s;
  logic             msb_cin_s, ovf_s, co_left_s, co_right_s;

  assign last_s = (idx_r == IDX_W'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s  = IDLE;
          finish_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Digit slice: select digit idx of each source word and apply the function.
  // Shift sources are whole pre-shifted words so bits crossing a digit
  // boundary come from the latched operand, never from the carry register.
  always_comb begin
    shl_w_s   = {a_r[WIDTH-2:0], cir_r};
    shr_w_s   = {cil_r, a_r[WIDTH-1:1]};
    a_sh_s    = a_r     >> (idx_r * DIGIT);
    b_sh_s    = b_r     >> (idx_r * DIGIT);
    l_sh_s    = shl_w_s >> (idx_r * DIGIT);
    r_sh_s    = shr_w_s >> (idx_r * DIGIT);
    a_dig_s   = a_sh_s[DIGIT-1:0];
    b_dig_s   = b_sh_s[DIGIT-1:0];
    shl_dig_s = l_sh_s[DIGIT-1:0];
    shr_dig_s = r_sh_s[DIGIT-1:0];
    sum_s     = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
    case (func_r)
      F_ADD:   raw_dig_s = sum_s[DIGIT-1:0];
      F_AND:   raw_dig_s = a_dig_s & b_dig_s;
      F_OR:    raw_dig_s = a_dig_s | b_dig_s;
      F_XOR:   raw_dig_s = a_dig_s ^ b_dig_s;
      F_PASSA: raw_dig_s = a_dig_s;
      F_PASSB: raw_dig_s = b_dig_s;
      F_SHR:   raw_dig_s = shr_dig_s;
      F_SHL:   raw_dig_s = shl_dig_s;
      default: raw_dig_s = {DIGIT{1'b0}};
    endcase
    out_dig_s = raw_dig_s ^ {DIGIT{com_r}};
    word_s    = {out_dig_s, work_r[WIDTH-1:DIGIT]};
    // Only meaningful on the top digit: carry into vs. out of the MSB
    msb_cin_s = a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1] ^ sum_s[DIGIT-1];
    ovf_s     = (func_r == F_ADD) ? (msb_cin_s ^ sum_s[DIGIT]) : 1'b0;
    if (func_r == F_ADD) begin
      co_left_s = sum_s[DIGIT];
    end else if (func_r == F_SHL) begin
      co_left_s = a_r[WIDTH-1];
    end else begin
      co_left_s = 1'b0;
    end
    co_right_s = (func_r == F_SHR) ? a_r[0] : 1'b0;
  end

  // Operand latch, digit sequencing and completion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      func_r     <= 3'd0;
      com_r      <= 1'b0;
      cir_r      <= 1'b0;
      cil_r      <= 1'b0;
      carry_r    <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      work_r     <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      co_left_r  <= 1'b0;
      co_right_r <= 1'b0;
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
      neg_zero_r <= 1'b0;
      equ_r      <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        a_r     <= bus.a;
        b_r     <= bus.b;
        func_r  <= bus.func;
        com_r   <= bus.com;
        cir_r   <= bus.ci_right;
        cil_r   <= bus.ci_left;
        carry_r <= bus.ci_right;
        idx_r   <= {IDX_W{1'b0}};
      end else if (step_s) begin
        work_r  <= word_s;
        carry_r <= sum_s[DIGIT];
        idx_r   <= idx_r + IDX_W'(1);
      end
      if (finish_s) begin
        result_r   <= word_s;
        co_left_r  <= co_left_s;
        co_right_r <= co_right_s;
        ovf_r      <= ovf_s;
        zero_r     <= (word_s == {WIDTH{1'b0}});
        neg_zero_r <= (word_s == {WIDTH{1'b1}});
        equ_r      <= (a_r == b_r);
      end
    end
  end

  assign bus.busy     = (state_r == RUN);
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.co_left  = co_left_r;
  assign bus.co_right = co_right_r;
  assign bus.ovf      = ovf_r;
  assign bus.zero     = zero_r;
  assign bus.neg_zero = neg_zero_r;
  assign bus.equ      = equ_r;

endmodule

// File: tb/tb_xalu_seq.sv
// Scoreboard bench for xalu_seq: the driver pushes word-level expected
// results when an operation is accepted; a monitor pops and compares on done.
module tb_xalu_seq;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  typedef logic [W+5:0] outs_t;  // {result, co_left, co_right, ovf, zero, neg_zero, equ}
  typedef struct {
    int    cyc;
    outs_t outs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   free_at = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  outs_t last_exp = '0;
  outs_t outs_now;

  xalu_seq_if #(.WIDTH(W)) bus ();

  xalu_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign outs_now = {bus.result, bus.co_left, bus.co_right, bus.ovf,
                     bus.zero, bus.neg_zero, bus.equ};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level reference model
  function automatic outs_t model(input logic [2:0] f, input logic cm,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cir, input logic cil);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         col, cor, ov;
    col = 1'b0; cor = 1'b0; ov = 1'b0; r = '0;
    case (f)
      3'd0: begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cir};
        r    = full[W-1:0];
        col  = full[W];
        ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a;
      3'd5: r = b;
      3'd6: begin r = {cil, a[W-1:1]}; cor = a[0]; end
      default: begin r = {a[W-2:0], cir}; col = a[W-1]; end
    endcase
    if (cm) r = ~r;
    return {r, col, cor, ov, (r == '0), (r == {W{1'b1}}), (a == b)};
  endfunction

  // Wait (scrambling inputs and pulsing ignored starts) until the model says
  // the ALU is free, then present the operation and log its expectation.
  task automatic issue(input logic [2:0] f, input logic cm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cir, input logic cil);
    exp_t e;
    while (cyc < free_at) begin
      bus.start    = 1'($urandom_range(0, 1));
      bus.func     = 3'($urandom);
      bus.com      = 1'($urandom);
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.ci_right = 1'($urandom);
      bus.ci_left  = 1'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b1; bus.func = f; bus.com = cm; bus.a = a; bus.b = b;
    bus.ci_right = cir; bus.ci_left = cil;
    e.cyc  = cyc + 1 + N;
    e.outs = model(f, cm, a, b, cir, cil);
    free_at = e.cyc;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: sample one time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (bus.done) begin
          chk("done_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("done_outs", 64'(outs_now), 64'(e.outs));
            last_exp = e.outs;
          end
        end else begin
          if (q.size() != 0 && cyc >= q[0].cyc) begin
            chk("done_missing", 64'd0, 64'd1);
            e = q.pop_front();
            last_exp = e.outs;
          end
          chk("hold_outs", 64'(outs_now), 64'(last_exp));
        end
        chk("busy", 64'(bus.busy), 64'(cyc < free_at));
        chk("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.func = 3'd0; bus.com = 1'b0; bus.a = '0; bus.b = '0;
    bus.ci_right = 1'b0; bus.ci_left = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'(outs_now), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations from the test plan
    issue(3'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(3'd0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue(3'd7, 1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0);
    issue(3'd6, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1);
    issue(3'd3, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);

    // Abort two cycles after start
    issue(3'd0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    free_at = 0;
    last_exp = '0;
    #1;
    chk("abort_outs", 64'(outs_now), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(3'd0, 1'b0, 16'h00FF, 16'h0F01, 1'b0, 1'b0);

    // Randomised operations with scrambled inputs/starts while busy
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        bus.start = 1'b0;
        while (cyc < free_at + 1) @(negedge clk);
      end
    end

    bus.start = 1'b0;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised, digit-serial successor to the 4-bit ALU slice. It latches two WIDTH-bit operands and a function code, then processes them DIGIT bits per clock, LSB digit first, with an internal carry register between digits. Results and status flags are registered and presented with a one-cycle done pulse. It sits between operand registers and the datapath writeback as a compact wide ALU that reuses one narrow slice in time.

## Interface
- WIDTH, 16: operand/result width; must be an integer multiple of DIGIT, at least 2·DIGIT.
- DIGIT, 4: bits processed per cycle. Define N = WIDTH/DIGIT (number of digit cycles).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- func  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- com  in  1  ones'-complement output mode; result inverted when 1.
- a, b  in  WIDTH  operands.
- ci_right  in  1  carry-in for ADD; shift-in bit for SHL.
- ci_left  in  1  shift-in bit for SHR.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result.
- co_left  out  1  ADD carry-out / SHL shifted-out MSB.
- co_right  out  1  SHR shifted-out LSB.
- ovf  out  1  signed overflow (ADD only).
- zero, neg_zero, equ  out  1  result all-0 / result all-1 / a==b.

## Operation
- States: IDLE, RUN. Reset forces IDLE; all outputs 0.
- IDLE + start: latch a, b, func, com, ci_left, ci_right; carry register := ci_right; digit index := 0; go to RUN.
- RUN: each cycle compute digit k (bits k·DIGIT+DIGIT-1 .. k·DIGIT) from the latched operands; append to a work register; increment index. After digit N-1, go to IDLE.
- Per-bit functions on the latched words: AND/OR/XOR/PASSA/PASSB bitwise. ADD: digit sum a_k + b_k + carry; carry register := digit carry-out. SHL: r[i] = a[i-1], r[0] = ci_right. SHR: r[i] = a[i+1], r[WIDTH-1] = ci_left. Shift bits crossing a digit boundary come from the latched word, not from the carry register.
- Output bits are XORed with latched com.
- At completion, in one edge, register: result = work word; co_left = final carry (ADD), a[WIDTH-1] (SHL), else 0; co_right = a[0] (SHR), else 0; ovf = carry into MSB XOR carry out of MSB (ADD), else 0; zero = (result == 0); neg_zero = (result == all ones); equ = (latched a == latched b).
- com does not affect co_left, co_right, ovf or equ.
- result and flags hold until the next completion. They do not change during RUN.
- start while busy is ignored and is not queued.
- Input changes during RUN have no effect.
- rst in any state, including mid-RUN: aborts the operation. No done pulse. Return to IDLE with all outputs 0.

## Timing
- start sampled high at edge E0 (IDLE): busy = 1 from E0.
- Digits processed on edges E1..EN.
- At EN: result and flags update, done = 1 for exactly one cycle, busy = 0.
- Latency from accepting edge to done: N cycles (4 for defaults).
- A new start may be asserted during the done cycle. It is accepted at EN+1. Maximum throughput is one operation per N+1 cycles.
- busy and done are never high together.

## Test plan
- Reset: rst=1 for 2 cycles -> busy=0, done=0, result=0x0000, all flags 0. Then ADD a=0x7FFF, b=0x0001, ci_right=0 -> done exactly 4 cycles after start, result=0x8000, ovf=1, co_left=0, zero=0.
- Carry ripple: ADD a=0xFFFF, b=0x0000, ci_right=1 -> result=0x0000, co_left=1, zero=1, ovf=0.
- Shifts: SHL a=0x8001, ci_right=1 -> result=0x0003, co_left=1. SHR a=0x0003, ci_left=1 -> result=0x8001, co_right=1.
- Complement and equality: XOR a=b=0x1234, com=1 -> result=0xFFFF, neg_zero=1, equ=1, zero=0.
- Handshake: second start pulsed while busy -> ignored, exactly one done pulse. start held high through the done cycle -> next operation accepted on the following edge, done 4 cycles later.
- Abort: rst asserted 2 cycles after start -> no done pulse, outputs 0, busy=0. The next operation completes correctly with unchanged latency.
